// File: rtl/sdram_pro_arbit_if.sv
// Bus bundle between the SDRAM command generators and the grant arbiter.
// The arbiter takes the slave view; generators and benches take the master view.
interface sdram_pro_arbit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int BANK_W = 2
);
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [BANK_W-1:0] init_bank;
    logic [ADDR_W-1:0] init_addr;

    logic              atref_req;
    logic              atref_end;
    logic [3:0]        atref_cmd;
    logic [BANK_W-1:0] atref_bank;
    logic [ADDR_W-1:0] atref_addr;
    logic              atref_en;

    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;

    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [BANK_W-1:0] rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;

    logic [3:0]        sdram_cmd;
    logic [BANK_W-1:0] sdram_bank;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_dq_out;
    logic              sdram_dq_oe;

    modport slave (
        input  init_end, init_cmd, init_bank, init_addr,
        input  atref_req, atref_end, atref_cmd, atref_bank, atref_addr,
        input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_data,
        input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
        output atref_en, wr_en, rd_en,
        output sdram_cmd, sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe
    );

    modport master (
        output init_end, init_cmd, init_bank, init_addr,
        output atref_req, atref_end, atref_cmd, atref_bank, atref_addr,
        output wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_data,
        output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
        input  atref_en, wr_en, rd_en,
        input  sdram_cmd, sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_pro_arbit.sv
// Fixed-priority grant arbiter (refresh > write > read) for the SDRAM command
// generators; muxes the granted generator's command bus and write data to the pins.
module sdram_pro_arbit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int BANK_W = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    sdram_pro_arbit_if.slave     bus
);
    localparam logic [3:0] NO_OPERATION = 4'b0111;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_ARBIT = 3'd1,
        ARB_ATREF = 3'd2,
        ARB_WRITE = 3'd3,
        ARB_READ  = 3'd4
    } arb_state_e;

    arb_state_e state_q, state_d;
    logic       atref_en_q, atref_en_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;

    logic atref_elig, wr_elig, rd_elig;

    // A source whose end flag is still high is not yet ready for another grant.
    assign atref_elig = bus.atref_req & ~bus.atref_end;
    assign wr_elig    = bus.wr_req    & ~bus.wr_end;
    assign rd_elig    = bus.rd_req    & ~bus.rd_end;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ARB_IDLE;
            atref_en_q <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            atref_en_q <= atref_en_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
        end
    end

    // Grant pulses are raised only on the ARBIT->grant transition, so they land
    // on the first cycle in the grant state and can never overlap.
    always_comb begin
        state_d    = state_q;
        atref_en_d = 1'b0;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (bus.init_end) state_d = ARB_ARBIT;
            end
            ARB_ARBIT: begin
                if (atref_elig) begin
                    state_d    = ARB_ATREF;
                    atref_en_d = 1'b1;
                end else if (wr_elig) begin
                    state_d = ARB_WRITE;
                    wr_en_d = 1'b1;
                end else if (rd_elig) begin
                    state_d = ARB_READ;
                    rd_en_d = 1'b1;
                end
            end
            ARB_ATREF: begin
                if (bus.atref_end) state_d = ARB_ARBIT;
            end
            ARB_WRITE: begin
                if (bus.wr_end) state_d = ARB_ARBIT;
            end
            ARB_READ: begin
                if (bus.rd_end) state_d = ARB_ARBIT;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    logic [3:0]        cmd_mux;
    logic [BANK_W-1:0] bank_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] dq_out_mux;
    logic              dq_oe_mux;

    always_comb begin
        cmd_mux    = bus.init_cmd;
        bank_mux   = bus.init_bank;
        addr_mux   = bus.init_addr;
        dq_out_mux = '0;
        dq_oe_mux  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                cmd_mux  = bus.init_cmd;
                bank_mux = bus.init_bank;
                addr_mux = bus.init_addr;
            end
            ARB_ARBIT: begin
                cmd_mux  = NO_OPERATION;
                bank_mux = {BANK_W{1'b1}};
                addr_mux = {ADDR_W{1'b1}};
            end
            ARB_ATREF: begin
                cmd_mux  = bus.atref_cmd;
                bank_mux = bus.atref_bank;
                addr_mux = bus.atref_addr;
            end
            ARB_WRITE: begin
                cmd_mux    = bus.wr_cmd;
                bank_mux   = bus.wr_bank;
                addr_mux   = bus.wr_addr;
                dq_out_mux = bus.wr_data;
                dq_oe_mux  = bus.wr_sdram_en;
            end
            ARB_READ: begin
                cmd_mux  = bus.rd_cmd;
                bank_mux = bus.rd_bank;
                addr_mux = bus.rd_addr;
            end
            default: begin
                cmd_mux  = bus.init_cmd;
                bank_mux = bus.init_bank;
                addr_mux = bus.init_addr;
            end
        endcase
    end

    assign bus.atref_en     = atref_en_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.rd_en        = rd_en_q;
    assign bus.sdram_cmd    = cmd_mux;
    assign bus.sdram_bank   = bank_mux;
    assign bus.sdram_addr   = addr_mux;
    assign bus.sdram_dq_out = dq_out_mux;
    assign bus.sdram_dq_oe  = dq_oe_mux;
endmodule

// File: tb/tb_sdram_pro_arbit.sv
// Vector-table bench for sdram_pro_arbit; expected outputs are queued when a
// vector is driven and popped for comparison one clock later.
module tb_sdram_pro_arbit;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int BANK_W = 2;

    localparam logic [3:0]  INIT_CMD  = 4'b1000;
    localparam logic [3:0]  WR_CMD    = 4'b0100;
    localparam logic [3:0]  RD_CMD    = 4'b0101;
    localparam logic [3:0]  NOP_CMD   = 4'b0111;
    localparam logic [1:0]  INIT_BANK = 2'd0;
    localparam logic [1:0]  AT_BANK   = 2'd1;
    localparam logic [1:0]  WR_BANK   = 2'd2;
    localparam logic [1:0]  RD_BANK   = 2'd3;
    localparam logic [11:0] INIT_ADDR = 12'h111;
    localparam logic [11:0] AT_ADDR   = 12'h222;
    localparam logic [11:0] WR_ADDR   = 12'h333;
    localparam logic [11:0] RD_ADDR   = 12'h444;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_AT, S_WR, S_RD} sel_e;

    typedef struct {
        logic        ie, ar, ae, wq, we, wse, rq, re;
        logic [3:0]  acmd;
        logic [15:0] wdata;
        sel_e        sel;
        logic        at_en, w_en, r_en;
    } vec_t;

    typedef struct {
        logic        at_en, w_en, r_en;
        logic [3:0]  cmd;
        logic [1:0]  bank;
        logic [11:0] addr;
        logic        oe;
        logic [15:0] dq;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    sdram_pro_arbit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus ();

    sdram_pro_arbit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    vec_t vecs[34];
    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(logic ie, logic ar, logic ae, logic wq, logic we, logic wse,
                                logic rq, logic re, logic [3:0] acmd, logic [15:0] wdata,
                                sel_e sel, logic at_en, logic w_en, logic r_en);
        vec_t v;
        v.ie = ie; v.ar = ar; v.ae = ae; v.wq = wq; v.we = we; v.wse = wse;
        v.rq = rq; v.re = re; v.acmd = acmd; v.wdata = wdata; v.sel = sel;
        v.at_en = at_en; v.w_en = w_en; v.r_en = r_en;
        return v;
    endfunction

    function automatic exp_t model(vec_t v);
        exp_t e;
        e.at_en = v.at_en; e.w_en = v.w_en; e.r_en = v.r_en;
        e.oe = 1'b0; e.dq = 16'h0000;
        case (v.sel)
            S_ARB:   begin e.cmd = NOP_CMD; e.bank = 2'b11;   e.addr = 12'hFFF; end
            S_AT:    begin e.cmd = v.acmd;  e.bank = AT_BANK; e.addr = AT_ADDR; end
            S_WR:    begin e.cmd = WR_CMD;  e.bank = WR_BANK; e.addr = WR_ADDR;
                           e.oe = v.wse; e.dq = v.wdata; end
            S_RD:    begin e.cmd = RD_CMD;  e.bank = RD_BANK; e.addr = RD_ADDR; end
            default: begin e.cmd = INIT_CMD; e.bank = INIT_BANK; e.addr = INIT_ADDR; end
        endcase
        return e;
    endfunction

    task automatic drive(vec_t v);
        bus.init_end    = v.ie;
        bus.atref_req   = v.ar;
        bus.atref_end   = v.ae;
        bus.atref_cmd   = v.acmd;
        bus.wr_req      = v.wq;
        bus.wr_end      = v.we;
        bus.wr_sdram_en = v.wse;
        bus.wr_data     = v.wdata;
        bus.rd_req      = v.rq;
        bus.rd_end      = v.re;
    endtask

    task automatic cmp1(string tag, string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s %s actual=%0h required=%0h", tag, name, act, req);
        end
    endtask

    task automatic compare(string tag);
        exp_t e;
        e = sb_q.pop_front();
        cmp1(tag, "atref_en", 32'(bus.atref_en), 32'(e.at_en));
        cmp1(tag, "wr_en", 32'(bus.wr_en), 32'(e.w_en));
        cmp1(tag, "rd_en", 32'(bus.rd_en), 32'(e.r_en));
        cmp1(tag, "sdram_cmd", 32'(bus.sdram_cmd), 32'(e.cmd));
        cmp1(tag, "sdram_bank", 32'(bus.sdram_bank), 32'(e.bank));
        cmp1(tag, "sdram_addr", 32'(bus.sdram_addr), 32'(e.addr));
        cmp1(tag, "sdram_dq_oe", 32'(bus.sdram_dq_oe), 32'(e.oe));
        cmp1(tag, "sdram_dq_out", 32'(bus.sdram_dq_out), 32'(e.dq));
        $display("%s: cmd=%b en=%b%b%b oe=%b dq=%h", tag, bus.sdram_cmd,
                 bus.atref_en, bus.wr_en, bus.rd_en, bus.sdram_dq_oe, bus.sdram_dq_out);
    endtask

    task automatic run_vec(int idx);
        @(negedge sys_clk);
        drive(vecs[idx]);
        sb_q.push_back(model(vecs[idx]));
        @(posedge sys_clk);
        #1;
        compare($sformatf("vec%0d", idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rst_v;
        //             ie ar ae wq we wse rq re acmd     wdata     sel    at w  r
        vecs[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 4'b0010, 16'h0000, S_IDLE, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 4'b0010, 16'h0000, S_IDLE, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 4'b0010, 16'h0000, S_ARB,  0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 4'b0010, 16'h0000, S_AT,   1, 0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 4'b0001, 16'h0000, S_AT,   0, 0, 0);
        vecs[5]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 4'b0001, 16'h0000, S_ARB,  0, 0, 0);
        vecs[6]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 4'b0001, 16'h0000, S_ARB,  0, 0, 0);
        vecs[7]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 4'b0001, 16'h0000, S_ARB,  0, 0, 0);
        vecs[8]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 4'b0001, 16'h0000, S_ARB,  0, 0, 0);
        vecs[9]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 4'b0001, 16'h0000, S_ARB,  0, 0, 0);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 16'h0000, S_ARB,  0, 0, 0);
        vecs[11] = mk(1, 1, 0, 1, 0, 0, 1, 0, 4'b0010, 16'h0000, S_AT,   1, 0, 0);
        vecs[12] = mk(1, 1, 0, 1, 0, 0, 1, 0, 4'b0001, 16'h0000, S_AT,   0, 0, 0);
        vecs[13] = mk(1, 1, 1, 1, 0, 0, 1, 0, 4'b0001, 16'h0000, S_ARB,  0, 0, 0);
        vecs[14] = mk(1, 0, 0, 1, 0, 0, 1, 0, 4'b0001, 16'hA5A5, S_WR,   0, 1, 0);
        vecs[15] = mk(1, 0, 0, 1, 0, 1, 1, 0, 4'b0001, 16'hA5A5, S_WR,   0, 0, 0);
        vecs[16] = mk(1, 0, 0, 1, 0, 1, 1, 0, 4'b0001, 16'hA5A5, S_WR,   0, 0, 0);
        vecs[17] = mk(1, 0, 0, 1, 0, 1, 1, 0, 4'b0001, 16'hA5A5, S_WR,   0, 0, 0);
        vecs[18] = mk(1, 0, 0, 1, 0, 1, 1, 0, 4'b0001, 16'hA5A5, S_WR,   0, 0, 0);
        vecs[19] = mk(1, 0, 0, 1, 0, 0, 1, 0, 4'b0001, 16'hA5A5, S_WR,   0, 0, 0);
        vecs[20] = mk(1, 0, 0, 0, 1, 1, 1, 0, 4'b0001, 16'hA5A5, S_ARB,  0, 0, 0);
        vecs[21] = mk(1, 0, 0, 0, 1, 1, 1, 0, 4'b0001, 16'hA5A5, S_RD,   0, 0, 1);
        vecs[22] = mk(1, 1, 0, 0, 0, 0, 1, 0, 4'b0001, 16'h0000, S_RD,   0, 0, 0);
        vecs[23] = mk(1, 1, 0, 0, 0, 0, 1, 0, 4'b0001, 16'h0000, S_RD,   0, 0, 0);
        vecs[24] = mk(1, 1, 0, 0, 0, 0, 0, 1, 4'b0001, 16'h0000, S_ARB,  0, 0, 0);
        vecs[25] = mk(1, 1, 0, 0, 0, 0, 0, 0, 4'b0010, 16'h0000, S_AT,   1, 0, 0);
        vecs[26] = mk(1, 0, 1, 0, 0, 0, 0, 0, 4'b0001, 16'h0000, S_ARB,  0, 0, 0);
        vecs[27] = mk(1, 0, 0, 1, 0, 0, 0, 0, 4'b0001, 16'h0000, S_WR,   0, 1, 0);
        vecs[28] = mk(1, 0, 0, 1, 0, 1, 0, 0, 4'b0001, 16'h1234, S_WR,   0, 0, 0);
        vecs[29] = mk(0, 1, 0, 1, 0, 0, 1, 0, 4'b0010, 16'h0000, S_IDLE, 0, 0, 0);
        vecs[30] = mk(0, 1, 0, 1, 0, 0, 1, 0, 4'b0010, 16'h0000, S_IDLE, 0, 0, 0);
        vecs[31] = mk(1, 1, 0, 1, 0, 0, 1, 0, 4'b0010, 16'h0000, S_ARB,  0, 0, 0);
        vecs[32] = mk(1, 1, 0, 1, 0, 0, 1, 0, 4'b0010, 16'h0000, S_AT,   1, 0, 0);
        vecs[33] = mk(1, 0, 1, 1, 0, 0, 1, 0, 4'b0010, 16'h0000, S_ARB,  0, 0, 0);

        bus.init_cmd   = INIT_CMD;  bus.init_bank  = INIT_BANK; bus.init_addr  = INIT_ADDR;
        bus.atref_bank = AT_BANK;   bus.atref_addr = AT_ADDR;
        bus.wr_cmd     = WR_CMD;    bus.wr_bank    = WR_BANK;   bus.wr_addr    = WR_ADDR;
        bus.rd_cmd     = RD_CMD;    bus.rd_bank    = RD_BANK;   bus.rd_addr    = RD_ADDR;

        // Reset held with a refresh request pending and init not finished.
        drive(vecs[0]);
        repeat (2) @(posedge sys_clk);
        #1;
        sb_q.push_back(model(vecs[0]));
        compare("reset");

        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 29; i++) run_vec(i);

        // Asynchronous reset mid-write, checked before the next rising edge.
        rst_v = mk(0, 1, 0, 1, 0, 1, 1, 0, 4'b0001, 16'h1234, S_IDLE, 0, 0, 0);
        @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        drive(rst_v);
        #1;
        sb_q.push_back(model(rst_v));
        compare("async_reset");
        @(posedge sys_clk);
        #1;
        sb_q.push_back(model(rst_v));
        compare("reset_hold");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        for (int i = 29; i < 34; i++) run_vec(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_pro_arbit.md
Name: sdram_pro_arbit

Overview:
Grant side of the SDRAM request/enable handshake. Receives requests from the init, auto-refresh, write and read command generators and grants exactly one of them at a time with a one-cycle enable pulse. It multiplexes the granted generator's cmd/bank/addr and write data onto the SDRAM pins, and sits between those generators and the SDRAM in the controller top.

Parameters:
DATA_W, 16, SDRAM DQ width
ADDR_W, 12, SDRAM address width
BANK_W, 2, SDRAM bank address width

Ports:
sys_clk  in  1  single system clock; all state changes on its rising edge
sys_rst_n  in  1  asynchronous active-low reset
init_end  in  1  initialization complete; stays high once set
init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
init_bank  in  BANK_W  init bank
init_addr  in  ADDR_W  init address
atref_req  in  1  refresh request; level, held until serviced
atref_end  in  1  refresh done; high for one or more cycles
atref_cmd / atref_bank / atref_addr  in  4 / BANK_W / ADDR_W  refresh command bus
atref_en  out  1  refresh grant pulse
wr_req  in  1  write request; level
wr_end  in  1  write burst done
wr_cmd / wr_bank / wr_addr  in  4 / BANK_W / ADDR_W  write command bus
wr_sdram_en  in  1  write generator drives DQ this cycle
wr_data  in  DATA_W  write data
wr_en  out  1  write grant pulse
rd_req  in  1  read request; level
rd_end  in  1  read burst done
rd_cmd / rd_bank / rd_addr  in  4 / BANK_W / ADDR_W  read command bus
rd_en  out  1  read grant pulse
sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to the SDRAM pins
sdram_bank  out  BANK_W  bank to the SDRAM
sdram_addr  out  ADDR_W  address to the SDRAM
sdram_dq_out  out  DATA_W  DQ output data
sdram_dq_oe  out  1  DQ output enable; 1 = drive

Behaviour:
- States: ARB_IDLE, ARB_ARBIT, ARB_ATREF, ARB_WRITE, ARB_READ. Two-register FSM, registered state.
- Reset:
  - state = ARB_IDLE.
  - atref_en, wr_en and rd_en = 0.
  - The output mux follows the init bus, so sdram_cmd shows whatever init_cmd drives.
  - sdram_dq_oe = 0 and sdram_dq_out = 0.
- ARB_IDLE -> ARB_ARBIT when init_end = 1. Requests arriving before init_end are held off and are not lost, because requests are levels.
- ARB_ARBIT uses fixed priority: refresh > write > read.
  - A source is eligible when req = 1 and its end = 0.
  - Next state is ARB_ATREF if atref eligible, else ARB_WRITE if wr eligible, else ARB_READ if rd eligible, else stay in ARB_ARBIT.
- Grant pulses:
  - atref_en, wr_en and rd_en are registered.
  - Each is high for exactly one cycle, the first cycle spent in the matching grant state.
  - They are never high at the same time, and never high outside that first cycle.
- Leaving a grant state:
  - ARB_ATREF -> ARB_ARBIT on the first cycle atref_end = 1.
  - ARB_WRITE -> ARB_ARBIT on wr_end = 1.
  - ARB_READ -> ARB_ARBIT on rd_end = 1.
  - Otherwise the FSM holds in the grant state with no timeout.
  - The end-qualified eligibility rule blocks regrant while a source's end is still high.
- Output mux (combinational from state):
  - ARB_IDLE: init_* buses.
  - ARB_ATREF: atref_* buses.
  - ARB_WRITE: wr_* buses.
  - ARB_READ: rd_* buses.
  - ARB_ARBIT: sdram_cmd = `NO_OPERATION (4'b0111), bank = all 1s, addr = all 1s.
- DQ:
  - sdram_dq_oe = 1 only when state = ARB_WRITE and wr_sdram_en = 1; otherwise 0.
  - sdram_dq_out = wr_data when state = ARB_WRITE, else 0.
- Simultaneous events: priority is resolved only in ARB_ARBIT, and a request that arrives during a grant waits its turn.
  - Refresh can starve read and write only if atref_req is held continuously. This does not happen in practice, because refresh is requested at most once every 750 cycles.
- Reset mid-operation: all outputs return to their reset values immediately and asynchronously. There is no resumption; after reset the FSM waits in ARB_IDLE for init_end.
- Illegal state encodings go to ARB_IDLE.

Test Plan:
- Reset with init_end = 0 and atref_req = 1 -> state stays ARB_IDLE, atref_en = 0, sdram_cmd = init_cmd. Raise init_end -> ARB_ARBIT next cycle, then atref_en pulses for 1 cycle one cycle later.
- Refresh handshake: atref_req = 1 in ARB_ARBIT -> one atref_en pulse; sdram_cmd tracks atref_cmd through precharge (4'b0010) and auto-refresh (4'b0001). Hold atref_end high for 4 cycles while atref_req drops after its first cycle -> exactly one grant, return to ARB_ARBIT with sdram_cmd = 4'b0111.
- Contention: atref_req, wr_req and rd_req all go high in the same cycle -> grants come in order atref, then wr after atref_end, then rd after wr_end. The three enable pulses never overlap.
- Write data: in ARB_WRITE drive wr_sdram_en = 1 for 4 cycles with wr_data = 16'hA5A5 -> sdram_dq_oe = 1 and sdram_dq_out = 16'hA5A5 in exactly those 4 cycles; sdram_dq_oe = 0 in every other state.
- Request during grant: raise atref_req mid-read -> rd continues until rd_end, then atref_en pulses the cycle after ARB_ARBIT is entered.
- Async reset asserted in ARB_WRITE -> sdram_dq_oe = 0 and the state is ARB_IDLE before the next clock edge; no enable pulses until init_end.
